// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes WORD_W-bit bitstream words onto a CHAIN_LEN-flop config chain (optional readback: CCFF_READBACK_EN).
// Latency: one prog_clk per chain bit plus start/done edges; readback adds a 2*CHAIN_LEN-cycle rotate-and-compare pass.
// Backpressure: word_ready is low while the one-word buffer still holds unsent bits; an empty buffer stalls the chain (clock enable low).
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int               BW       = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BW-1:0]    FULL     = BW'(WORD_W);

`ifdef CCFF_READBACK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t            state;
    logic [CNT_W-1:0]  bitcnt;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     buf_cnt;
    logic              accept;

    // A new word may land in the same cycle the buffer's last bit goes out, unless that bit ends the load.
    assign word_ready = (state == SHIFT) &&
                        ((buf_cnt == '0) || ((buf_cnt == BW'(1)) && (bitcnt < LAST_BIT)));
    assign accept     = word_valid && word_ready;

`ifdef CCFF_READBACK_EN
    logic [15:0]      crc_load;
    logic [15:0]      crc_tail;
    logic [CNT_W-1:0] vcnt;
    logic             vphase;
    logic             err_r;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    assign err = err_r;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            buf_cnt     <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CCFF_READBACK_EN
            crc_load    <= 16'hFFFF;
            crc_tail    <= 16'hFFFF;
            vcnt        <= '0;
            vphase      <= 1'b0;
            err_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ccff_clk_en <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    // busy is still high on the done-pulse cycle, so a start there is ignored too
                    if (start && !busy) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bitcnt  <= '0;
                        buf_cnt <= '0;
                        shreg   <= '0;
`ifdef CCFF_READBACK_EN
                        crc_load <= 16'hFFFF;
                        crc_tail <= 16'hFFFF;
                        err_r    <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    if (buf_cnt != '0) begin
                        ccff_head   <= shreg[0];
                        ccff_clk_en <= 1'b1;
                        bitcnt      <= bitcnt + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                        crc_load    <= crc16_step(crc_load, shreg[0]);
`endif
                        if (bitcnt == LAST_BIT) begin
                            buf_cnt <= '0;
`ifdef CCFF_READBACK_EN
                            state   <= VERIFY;
                            vcnt    <= '0;
                            vphase  <= 1'b0;
`else
                            state   <= DONE;
`endif
                        end else if (accept) begin
                            shreg   <= word_data;
                            buf_cnt <= FULL;
                        end else begin
                            shreg   <= shreg >> 1;
                            buf_cnt <= buf_cnt - BW'(1);
                        end
                    end else begin
                        ccff_clk_en <= 1'b0;
                        if (accept) begin
                            shreg   <= word_data;
                            buf_cnt <= FULL;
                        end
                    end
                end

`ifdef CCFF_READBACK_EN
                // Enables alternate with idle cycles: head is registered, so the tail is
                // sampled only after the chain has taken the previous enabled shift.
                VERIFY: begin
                    if (!vphase) begin
                        ccff_clk_en <= 1'b0;
                        if (vcnt == CNT_W'(CHAIN_LEN)) begin
                            err_r <= (crc_load != crc_tail);
                            state <= DONE;
                        end else begin
                            vphase <= 1'b1;
                        end
                    end else begin
                        ccff_head   <= ccff_tail;
                        ccff_clk_en <= 1'b1;
                        crc_tail    <= crc16_step(crc_tail, ccff_tail);
                        vcnt        <= vcnt + CNT_W'(1);
                        vphase      <= 1'b0;
                    end
                end
`endif

                DONE: begin
                    ccff_clk_en <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: table vectors, hand-written corner sequences and random loads against a word-concatenation model.
module tb_ccff_chain_loader;
    localparam int CHAIN_LEN = 12;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 16;
`ifdef CCFF_READBACK_EN
    localparam int EXP_EN = 2 * CHAIN_LEN;
`else
    localparam int EXP_EN = CHAIN_LEN;
`endif

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              start;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              err;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ccff_head  (ccff_head),
        .ccff_clk_en(ccff_clk_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Target chain: flop 0 takes ccff_head, flop CHAIN_LEN-1 drives ccff_tail; flop 5 can be stuck at 0.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] chain_eff;
    bit                   stuck5 = 1'b0;

    always_comb begin
        chain_eff = chain;
        if (stuck5) chain_eff[5] = 1'b0;
    end
    assign ccff_tail = chain_eff[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        if (ccff_clk_en) chain <= {chain_eff[CHAIN_LEN-2:0], ccff_head};
    end

    bit mon_bits[$];
    int acc_cnt, done_cnt, feed_viol, starve_cyc;
    int checks = 0;
    int errors = 0;

    always @(negedge prog_clk) begin
        if (!pReset) begin
            if (ccff_clk_en) begin
                // a bit can never go out before the word that carries it was accepted
                if (mon_bits.size() < CHAIN_LEN && mon_bits.size() >= WORD_W * acc_cnt) feed_viol++;
                mon_bits.push_back(ccff_head);
            end
            if (done) done_cnt++;
            if (busy && !ccff_clk_en && mon_bits.size() == WORD_W) starve_cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CHAIN_LEN-1:0] ref_bits(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
        logic [2*WORD_W-1:0] stream;
        stream = {w1, w0};
        return stream[CHAIN_LEN-1:0];
    endfunction

    function automatic logic [CHAIN_LEN-1:0] first_bits();
        logic [CHAIN_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < CHAIN_LEN && i < mon_bits.size(); i++) r[i] = mon_bits[i];
        return r;
    endfunction

    function automatic logic [CHAIN_LEN-1:0] rev_bits(input logic [CHAIN_LEN-1:0] x);
        logic [CHAIN_LEN-1:0] r;
        for (int i = 0; i < CHAIN_LEN; i++) r[CHAIN_LEN-1-i] = x[i];
        return r;
    endfunction

    // Entered and left on a negedge. Presents w0, w1 (after gap1 idle cycles) then an extra word
    // that must never be accepted; optionally pulses start again at cycle restart_at.
    task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                            input int gap0, input int gap1, input int restart_at, output bit finished);
        logic [WORD_W-1:0] ws [3];
        int wi, gap_left, cyc;
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = ~w1;
        mon_bits.delete();
        acc_cnt = 0; done_cnt = 0; feed_viol = 0; starve_cyc = 0;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        wi = 0; gap_left = gap0; cyc = 0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            start = (cyc == restart_at);
            if (gap_left > 0) begin
                word_valid = 1'b0;
                word_data  = '0;
                gap_left--;
            end else begin
                word_valid = 1'b1;
                word_data  = ws[wi];
            end
            #1;
            if (word_valid && word_ready) begin
                acc_cnt++;
                if (wi < 2) wi++;
                gap_left = (wi == 1) ? gap1 : 0;
            end
            if (done_cnt > 0) finished = 1'b1;
            @(negedge prog_clk);
            cyc++;
        end
        start = 1'b0;
        word_valid = 1'b0;
        repeat (3) @(negedge prog_clk);
    endtask

    task automatic check_load(input string name, input logic [CHAIN_LEN-1:0] exp, input int exp_err, input bit finished);
        chk({name, "_timeout"}, int'(finished), 1);
        chk({name, "_en_cycles"}, mon_bits.size(), EXP_EN);
        chk({name, "_bits"}, int'(first_bits()), int'(exp));
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_words_accepted"}, acc_cnt, 2);
        chk({name, "_feed_order"}, feed_viol, 0);
        chk({name, "_idle_outputs"}, int'({busy, done, ccff_clk_en, word_ready}), 0);
        chk({name, "_err"}, int'(err), exp_err);
        if (!stuck5) chk({name, "_chain_contents"}, int'(chain), int'(rev_bits(exp)));
    endtask

    typedef struct {
        logic [WORD_W-1:0]    w0;
        logic [WORD_W-1:0]    w1;
        int                   gap1;
        int                   restart_at;
        logic [CHAIN_LEN-1:0] exp;
    } vec_t;

    initial begin
        vec_t              vecs [6];
        bit                fin;
        int                n, g0, g1, ra;
        logic [WORD_W-1:0] w0, w1;

        vecs[0] = '{8'hA5, 8'h3C, 0, -1, 12'hCA5};   // basic back-to-back load
        vecs[1] = '{8'hA5, 8'h3C, 13, -1, 12'hCA5};  // source starves the buffer
        vecs[2] = '{8'hA5, 8'h3C, 0, 4, 12'hCA5};    // start pulsed mid-load
        vecs[3] = '{8'hFF, 8'h00, 2, -1, 12'h0FF};
        vecs[4] = '{8'h00, 8'hFF, 5, 7, 12'hF00};
        vecs[5] = '{8'h5A, 8'hC3, 1, -1, 12'h35A};

        pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0;
        repeat (2) @(negedge prog_clk);
        chk("reset_outputs", int'({ccff_head, ccff_clk_en, busy, done, err, word_ready}), 0);
        pReset = 1'b0;
        @(negedge prog_clk);

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i].w0, vecs[i].w1, 0, vecs[i].gap1, vecs[i].restart_at, fin);
            check_load($sformatf("vec%0d", i), vecs[i].exp, 0, fin);
            if (i == 1) chk("stall_chain_idle_cycles", int'(starve_cyc >= 5), 1);
        end

        // Reset in the middle of a load, then a full reload from bit 0.
        mon_bits.delete();
        acc_cnt = 2;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        word_valid = 1'b1;
        word_data  = 8'hA5;
        n = 0;
        while (mon_bits.size() < 5 && n < 50) begin
            @(negedge prog_clk);
            n++;
        end
        chk("midreset_reached_5_bits", int'(mon_bits.size() >= 5), 1);
        pReset = 1'b1;
        #2;
        chk("midreset_outputs", int'({ccff_head, ccff_clk_en, busy, done, err, word_ready}), 0);
        @(negedge prog_clk);
        pReset = 1'b0;
        word_valid = 1'b0;
        @(negedge prog_clk);
        run_load(8'hA5, 8'h3C, 0, 0, -1, fin);
        check_load("midreset_reload", 12'hCA5, 0, fin);

`ifdef CCFF_READBACK_EN
        stuck5 = 1'b1;
        run_load(8'hFF, 8'hFF, 0, 0, -1, fin);
        check_load("readback_stuck", 12'hFFF, 1, fin);
        stuck5 = 1'b0;
`endif

        for (int k = 0; k < 20; k++) begin
            w0 = WORD_W'($urandom);
            w1 = WORD_W'($urandom);
            g0 = int'($urandom_range(0, 3));
            g1 = int'($urandom_range(0, 12));
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            run_load(w0, w1, g0, g1, ra, fin);
            check_load($sformatf("rand%0d", k), ref_bits(w0, w1), 0, fin);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
